// File: rtl/mem_command_port_buf.sv
// Command port buffer: decodes an opcode/address header from the byte bus, hands the
// command byte to the FSM, then moves payload through a small FIFO in the direction the opcode implies.
module mem_command_port_buf #(
  parameter int         ADDR_BYTES = 3,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [1:0] PORT_ID    = 2'b00
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_bus_valid,
  input  logic                        in_bus_ready,
  input  logic [7:0]                  in_bus_data,
  output logic                        out_bus_valid,
  output logic                        out_bus_ready,
  output logic [7:0]                  out_bus_data,
  input  logic                        in_ack_bus_owned,
  output logic                        out_ack_bus_request,
  output logic [1:0]                  out_ack_bus_id,
  output logic                        out_fsm_valid,
  output logic [7:0]                  out_fsm_data,
  input  logic                        in_fsm_ready,
  input  logic                        in_fsm_valid,
  input  logic [7:0]                  in_fsm_data,
  output logic                        out_fsm_ready,
  input  logic                        in_fsm_done,
  output logic                        out_fsm_enc_type,
  output logic [1:0]                  out_fsm_opcode,
  output logic [8*ADDR_BYTES-1:0]     out_address,
  output logic                        out_busy,
  output logic [$clog2(FIFO_DEPTH):0] out_fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] OP_RD_KEY  = 2'b00;
  localparam logic [1:0] OP_RD_TEXT = 2'b01;
  localparam logic [1:0] OP_WR_RES  = 2'b10;

  typedef enum logic [2:0] {IDLE, ADDR, CMD, XFER, ACK_REQ, ACK_DONE} state_t;

  state_t                  state_q, state_d;
  logic [7:0]              cmd_q, cmd_d;
  logic [1:0]              opcode_q, opcode_d;
  logic                    enc_q, enc_d;
  logic [8*ADDR_BYTES-1:0] addr_q, addr_d;
  logic [1:0]              addr_cnt_q, addr_cnt_d;
  logic                    done_q, done_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [7:0]              mem_q [FIFO_DEPTH];
  logic [7:0]              mem_d [FIFO_DEPTH];

  logic       is_write;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_head;
  logic       push;
  logic       pop;
  logic [7:0] push_data;
  logic       bus_accept;
  logic       hdr_match;

  assign is_write   = (opcode_q == OP_WR_RES);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign fifo_head  = mem_q[rd_ptr_q];

  assign out_fsm_enc_type = enc_q;
  assign out_fsm_opcode   = opcode_q;
  assign out_address      = addr_q;
  assign out_busy         = (state_q != IDLE);
  assign out_fifo_count   = count_q;

  assign bus_accept = in_bus_valid && out_bus_ready;
  assign hdr_match  = (((in_bus_data[1:0] == OP_RD_KEY) || (in_bus_data[1:0] == OP_RD_TEXT)) &&
                       (in_bus_data[5:4] == PORT_ID)) ||
                      ((in_bus_data[1:0] == OP_WR_RES) && (in_bus_data[3:2] == PORT_ID));

  // Handshake outputs; the data outputs read zero whenever their valid is low.
  always_comb begin
    out_bus_ready       = 1'b0;
    out_bus_valid       = 1'b0;
    out_bus_data        = 8'h00;
    out_fsm_valid       = 1'b0;
    out_fsm_data        = 8'h00;
    out_fsm_ready       = 1'b0;
    out_ack_bus_request = 1'b0;
    out_ack_bus_id      = 2'b00;
    push                = 1'b0;
    pop                 = 1'b0;
    push_data           = 8'h00;
    case (state_q)
      IDLE, ADDR: out_bus_ready = 1'b1;
      CMD: begin
        out_fsm_valid = 1'b1;
        out_fsm_data  = cmd_q;
      end
      XFER: begin
        if (is_write) begin
          out_bus_ready = !fifo_full && !done_q;
          out_fsm_valid = !fifo_empty;
          out_fsm_data  = fifo_empty ? 8'h00 : fifo_head;
          push          = in_bus_valid && !fifo_full && !done_q;
          push_data     = in_bus_data;
          pop           = in_fsm_ready && !fifo_empty;
        end else begin
          out_fsm_ready = !fifo_full;
          out_bus_valid = !fifo_empty;
          out_bus_data  = fifo_empty ? 8'h00 : fifo_head;
          push          = in_fsm_valid && !fifo_full;
          push_data     = in_fsm_data;
          pop           = in_bus_ready && !fifo_empty;
        end
      end
      ACK_REQ: begin
        out_ack_bus_request = 1'b1;
        out_ack_bus_id      = PORT_ID;
      end
      default: ;
    endcase
  end

  // Next-state, command capture and FIFO bookkeeping; entering IDLE flushes the FIFO and done latch.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    opcode_d   = opcode_q;
    enc_d      = enc_q;
    addr_d     = addr_q;
    addr_cnt_d = addr_cnt_q;
    done_d     = done_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    mem_d      = mem_q;

    case (state_q)
      IDLE: begin
        if (bus_accept && hdr_match) begin
          state_d    = ADDR;
          cmd_d      = in_bus_data;
          opcode_d   = in_bus_data[1:0];
          enc_d      = in_bus_data[7];
          addr_cnt_d = 2'd0;
        end
      end
      ADDR: begin
        if (bus_accept) begin
          for (int i = 0; i < ADDR_BYTES; i++) begin
            if (addr_cnt_q == 2'(i)) addr_d[i*8 +: 8] = in_bus_data;
          end
          if (addr_cnt_q == 2'(ADDR_BYTES - 1)) state_d = CMD;
          else addr_cnt_d = addr_cnt_q + 2'd1;
        end
      end
      CMD: if (in_fsm_ready) state_d = XFER;
      XFER: begin
        if (is_write) begin
          if (done_q || in_fsm_done) state_d = IDLE;
        end else if (done_q && fifo_empty && !in_fsm_valid) begin
          state_d = ACK_REQ;
        end
      end
      ACK_REQ: if (in_ack_bus_owned) state_d = ACK_DONE;
      ACK_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if ((state_q != IDLE) && in_fsm_done) done_d = 1'b1;

    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if ((state_q != IDLE) && (state_d == IDLE)) begin
      done_d   = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cmd_q      <= 8'h00;
      opcode_q   <= 2'b00;
      enc_q      <= 1'b0;
      addr_q     <= '0;
      addr_cnt_q <= 2'd0;
      done_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      opcode_q   <= opcode_d;
      enc_q      <= enc_d;
      addr_q     <= addr_d;
      addr_cnt_q <= addr_cnt_d;
      done_q     <= done_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      mem_q      <= mem_d;
    end
  end

endmodule

// File: tb/tb_mem_command_port_buf.sv
// Directed bench for mem_command_port_buf: stimulus pushes expected bytes into queues,
// a negedge monitor pops and compares on every FSM/bus handshake.
module tb_mem_command_port_buf;

  localparam int FD = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       in_bus_valid, in_bus_ready, in_ack_bus_owned;
  logic [7:0] in_bus_data, in_fsm_data;
  logic       in_fsm_ready, in_fsm_valid, in_fsm_done;
  logic       out_bus_valid, out_bus_ready, out_ack_bus_request;
  logic [7:0] out_bus_data, out_fsm_data;
  logic [1:0] out_ack_bus_id, out_fsm_opcode;
  logic       out_fsm_valid, out_fsm_ready, out_fsm_enc_type, out_busy;
  logic [23:0] out_address;
  logic [$clog2(FD):0] out_fifo_count;

  logic       b4_valid;
  logic [7:0] b4_data;
  logic       o4_bus_valid, o4_bus_ready, o4_ack_req, o4_fsm_valid, o4_fsm_ready, o4_enc, o4_busy;
  logic [7:0] o4_bus_data, o4_fsm_data;
  logic [1:0] o4_ack_id, o4_opcode;
  logic [31:0] o4_address;
  logic [2:0] o4_count;

  int checks = 0;
  int failures = 0;
  int ack_count = 0;
  logic [7:0] exp_fsm_q[$];
  logic [7:0] exp_bus_q[$];

  mem_command_port_buf #(.ADDR_BYTES(3), .FIFO_DEPTH(FD), .PORT_ID(2'b00)) dut (
    .clk(clk), .rst(rst),
    .in_bus_valid(in_bus_valid), .in_bus_ready(in_bus_ready), .in_bus_data(in_bus_data),
    .out_bus_valid(out_bus_valid), .out_bus_ready(out_bus_ready), .out_bus_data(out_bus_data),
    .in_ack_bus_owned(in_ack_bus_owned), .out_ack_bus_request(out_ack_bus_request),
    .out_ack_bus_id(out_ack_bus_id),
    .out_fsm_valid(out_fsm_valid), .out_fsm_data(out_fsm_data), .in_fsm_ready(in_fsm_ready),
    .in_fsm_valid(in_fsm_valid), .in_fsm_data(in_fsm_data), .out_fsm_ready(out_fsm_ready),
    .in_fsm_done(in_fsm_done),
    .out_fsm_enc_type(out_fsm_enc_type), .out_fsm_opcode(out_fsm_opcode), .out_address(out_address),
    .out_busy(out_busy), .out_fifo_count(out_fifo_count)
  );

  mem_command_port_buf #(.ADDR_BYTES(4), .FIFO_DEPTH(FD), .PORT_ID(2'b00)) dut4 (
    .clk(clk), .rst(rst),
    .in_bus_valid(b4_valid), .in_bus_ready(1'b0), .in_bus_data(b4_data),
    .out_bus_valid(o4_bus_valid), .out_bus_ready(o4_bus_ready), .out_bus_data(o4_bus_data),
    .in_ack_bus_owned(1'b0), .out_ack_bus_request(o4_ack_req), .out_ack_bus_id(o4_ack_id),
    .out_fsm_valid(o4_fsm_valid), .out_fsm_data(o4_fsm_data), .in_fsm_ready(1'b0),
    .in_fsm_valid(1'b0), .in_fsm_data(8'h00), .out_fsm_ready(o4_fsm_ready),
    .in_fsm_done(1'b0),
    .out_fsm_enc_type(o4_enc), .out_fsm_opcode(o4_opcode), .out_address(o4_address),
    .out_busy(o4_busy), .out_fifo_count(o4_count)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic report_timeout(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=timeout expected=handshake", name);
  endtask

  // Scoreboard monitor: a handshake seen at negedge completes on the following posedge.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_fsm_valid && in_fsm_ready) begin
        if (exp_fsm_q.size() == 0) report_timeout("fsm_unexpected_handshake");
        else checkOutput("fsm_data", {24'h0, out_fsm_data}, {24'h0, exp_fsm_q.pop_front()});
      end
      if (out_bus_valid && in_bus_ready) begin
        if (exp_bus_q.size() == 0) report_timeout("bus_unexpected_handshake");
        else checkOutput("bus_data", {24'h0, out_bus_data}, {24'h0, exp_bus_q.pop_front()});
      end
      if (out_ack_bus_request && in_ack_bus_owned) begin
        ack_count++;
        checkOutput("ack_id", {30'h0, out_ack_bus_id}, 32'h0);
      end
    end
  end

  // Offers one byte on the input bus from posedge+1 and returns at posedge+1 after acceptance.
  task automatic applyStimulus(input logic [7:0] b);
    int n = 0;
    in_bus_valid = 1'b1;
    in_bus_data  = b;
    @(negedge clk);
    while (!out_bus_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_bus_ready) report_timeout("bus_send");
    @(posedge clk);
    #1 in_bus_valid = 1'b0;
  endtask

  task automatic fsm_send(input logic [7:0] b);
    int n = 0;
    in_fsm_valid = 1'b1;
    in_fsm_data  = b;
    @(negedge clk);
    while (!out_fsm_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_fsm_ready) report_timeout("fsm_send");
    @(posedge clk);
    #1 in_fsm_valid = 1'b0;
  endtask

  task automatic pulse_done();
    in_fsm_done = 1'b1;
    @(posedge clk);
    #1 in_fsm_done = 1'b0;
  endtask

  task automatic wait_cmd_and_take();
    int n = 0;
    @(negedge clk);
    while (!out_fsm_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_fsm_valid) report_timeout("cmd_valid");
    @(posedge clk);
    #1 in_fsm_ready = 1'b1;
    @(posedge clk);
    #1 in_fsm_ready = 1'b0;
  endtask

  task automatic ack_and_idle();
    int n = 0;
    @(negedge clk);
    while (!out_ack_bus_request && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ack_request", {31'h0, out_ack_bus_request}, 32'h1);
    checkOutput("ack_bus_id", {30'h0, out_ack_bus_id}, 32'h0);
    @(posedge clk);
    #1 in_ack_bus_owned = 1'b1;
    @(posedge clk);
    #1 in_ack_bus_owned = 1'b0;
    n = 0;
    @(negedge clk);
    while (out_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("back_to_idle", {31'h0, out_busy}, 32'h0);
    checkOutput("idle_ack_request", {31'h0, out_ack_bus_request}, 32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1;
    in_bus_valid = 0; in_bus_ready = 0; in_bus_data = 0; in_ack_bus_owned = 0;
    in_fsm_ready = 0; in_fsm_valid = 0; in_fsm_data = 0; in_fsm_done = 0;
    b4_valid = 0; b4_data = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    checkOutput("reset_busy", {31'h0, out_busy}, 32'h0);
    checkOutput("reset_count", {29'h0, out_fifo_count}, 32'h0);
    checkOutput("reset_address", {8'h0, out_address}, 32'h0);
    checkOutput("reset_cmd_fields", {29'h0, out_fsm_enc_type, out_fsm_opcode}, 32'h0);
    checkOutput("reset_bus_ready", {31'h0, out_bus_ready}, 32'h1);
    checkOutput("reset_valids", {29'h0, out_fsm_valid, out_bus_valid, out_ack_bus_request}, 32'h0);

    // Read transaction: header 01 11 22 33, FSM streams A0..A7
    @(posedge clk);
    #1 in_fsm_ready = 1'b1; in_bus_ready = 1'b1;
    exp_fsm_q.push_back(8'h01);
    applyStimulus(8'h01); applyStimulus(8'h11); applyStimulus(8'h22); applyStimulus(8'h33);
    @(negedge clk);
    checkOutput("read_address", {8'h0, out_address}, 32'h0033_2211);
    checkOutput("read_opcode", {30'h0, out_fsm_opcode}, 32'h1);
    checkOutput("read_busy", {31'h0, out_busy}, 32'h1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      exp_bus_q.push_back(8'hA0 + 8'(i));
      fsm_send(8'hA0 + 8'(i));
    end
    pulse_done();
    ack_and_idle();
    checkOutput("read_ack_count", ack_count, 32'd1);
    checkOutput("read_bus_drained", exp_bus_q.size(), 32'd0);
    checkOutput("read_cmd_seen", exp_fsm_q.size(), 32'd0);

    // Filtered headers: OTHER opcode, then RD_TEXT addressed to port 1
    applyStimulus(8'h03);
    applyStimulus(8'h11);
    @(negedge clk);
    checkOutput("filter_busy", {31'h0, out_busy}, 32'h0);
    checkOutput("filter_address_kept", {8'h0, out_address}, 32'h0033_2211);
    checkOutput("filter_opcode_kept", {30'h0, out_fsm_opcode}, 32'h1);
    checkOutput("filter_fsm_valid", {31'h0, out_fsm_valid}, 32'h0);
    @(posedge clk);
    #1 in_fsm_ready = 1'b0;

    // Write with FSM stalled: FIFO fills at 4, then drains in order
    exp_fsm_q.push_back(8'h02);
    applyStimulus(8'h02); applyStimulus(8'h44); applyStimulus(8'h55); applyStimulus(8'h66);
    wait_cmd_and_take();
    @(negedge clk);
    checkOutput("write_address", {8'h0, out_address}, 32'h0066_5544);
    checkOutput("write_opcode", {30'h0, out_fsm_opcode}, 32'h2);
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          exp_fsm_q.push_back(8'hD0 + 8'(i));
          applyStimulus(8'hD0 + 8'(i));
        end
      end
      begin
        int m = 0;
        @(negedge clk);
        while (out_fifo_count != 3'd4 && m < 50) begin
          @(negedge clk);
          m++;
        end
        checkOutput("write_full_count", {29'h0, out_fifo_count}, 32'd4);
        checkOutput("write_full_bus_ready", {31'h0, out_bus_ready}, 32'h0);
        @(negedge clk);
        checkOutput("write_stalled_count", {29'h0, out_fifo_count}, 32'd4);
        checkOutput("write_head", {24'h0, out_fsm_data}, 32'hD0);
        @(posedge clk);
        #1 in_fsm_ready = 1'b1;
      end
    join
    n = 0;
    @(negedge clk);
    while (exp_fsm_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("write_drained", exp_fsm_q.size(), 32'd0);
    @(posedge clk);
    #1 in_fsm_ready = 1'b0;
    pulse_done();
    @(negedge clk);
    checkOutput("write_exit_idle", {31'h0, out_busy}, 32'h0);
    checkOutput("write_exit_count", {29'h0, out_fifo_count}, 32'd0);

    // Read with a full FIFO, then push and pop together through several pointer wraps
    @(posedge clk);
    #1 in_bus_ready = 1'b0; in_fsm_ready = 1'b1;
    exp_fsm_q.push_back(8'h00);
    applyStimulus(8'h00); applyStimulus(8'h01); applyStimulus(8'h02); applyStimulus(8'h03);
    for (int i = 0; i < 4; i++) begin
      exp_bus_q.push_back(8'hB0 + 8'(i));
      fsm_send(8'hB0 + 8'(i));
    end
    @(negedge clk);
    checkOutput("full_read_count", {29'h0, out_fifo_count}, 32'd4);
    checkOutput("full_read_fsm_ready", {31'h0, out_fsm_ready}, 32'h0);
    checkOutput("full_read_head", {23'h0, out_bus_valid, out_bus_data}, 32'h1B0);
    @(posedge clk);
    #1 in_bus_ready = 1'b1;
    for (int i = 4; i < 12; i++) begin
      exp_bus_q.push_back(8'hB0 + 8'(i));
      fsm_send(8'hB0 + 8'(i));
    end
    pulse_done();
    ack_and_idle();
    checkOutput("full_read_ack_count", ack_count, 32'd2);
    checkOutput("full_read_drained", exp_bus_q.size(), 32'd0);

    // Reset in the middle of a write with 3 bytes buffered
    in_fsm_ready = 1'b0; in_bus_ready = 1'b0;
    exp_fsm_q.push_back(8'h02);
    applyStimulus(8'h02); applyStimulus(8'h07); applyStimulus(8'h08); applyStimulus(8'h09);
    wait_cmd_and_take();
    applyStimulus(8'hE0); applyStimulus(8'hE1); applyStimulus(8'hE2);
    @(negedge clk);
    checkOutput("midrst_count_before", {29'h0, out_fifo_count}, 32'd3);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_busy", {31'h0, out_busy}, 32'h0);
    checkOutput("midrst_count", {29'h0, out_fifo_count}, 32'd0);
    checkOutput("midrst_cmd_outputs", {5'h0, out_fsm_enc_type, out_fsm_opcode, out_address}, 32'h0);
    checkOutput("midrst_data_outputs",
                {10'h0, out_fsm_valid, out_fsm_data, out_bus_valid, out_bus_data,
                 out_ack_bus_request, out_ack_bus_id, out_fsm_ready}, 32'h0);
    @(posedge clk);
    #1 in_fsm_ready = 1'b1; in_bus_ready = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("midrst_still_idle", {31'h0, out_busy}, 32'h0);
    @(posedge clk);
    #1 in_fsm_ready = 1'b0; in_bus_ready = 1'b0;

    // Four-byte address build
    for (int i = 0; i < 5; i++) begin
      b4_valid = 1'b1;
      b4_data  = 8'(i);
      @(posedge clk);
      #1;
    end
    b4_valid = 1'b0;
    @(negedge clk);
    checkOutput("addr4_address", o4_address, 32'h0403_0201);
    checkOutput("addr4_cmd_valid", {23'h0, o4_fsm_valid, o4_fsm_data}, 32'h100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
